// File: rtl/reg_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// reg_bus_arbiter_if
//   Groups the signals around the register-bus arbiter: the two requester
//   handshakes (master 0 = SPI front end, master 1 = I2C front end) and the
//   shared register-file bus with its write/read strobes.
//
//   Signals
//     mN_req/we/addr/wdata : request from master N (held until mN_ack)
//     mN_ack/err/rdata     : one-cycle completion, error flag, read data
//     address/wdata        : register bus address and write data
//     xfc / rd_stb         : one-cycle write / read strobes
//     rdata                : register file read data
//     busy                 : arbiter not idle
//
//   Modports
//     slave  : the arbiter's view (takes requests, drives the register bus)
//     master : the surrounding logic's view (requesters + register file)
// ---------------------------------------------------------------------------
interface reg_bus_arbiter_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
);
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_ack;
    logic              m0_err;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_ack;
    logic              m1_err;
    logic [DATA_W-1:0] m1_rdata;

    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] wdata;
    logic              xfc;
    logic              rd_stb;
    logic [DATA_W-1:0] rdata;
    logic              busy;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  rdata,
        output m0_ack, m0_err, m0_rdata,
        output m1_ack, m1_err, m1_rdata,
        output address, wdata, xfc, rd_stb, busy
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output rdata,
        input  m0_ack, m0_err, m0_rdata,
        input  m1_ack, m1_err, m1_rdata,
        input  address, wdata, xfc, rd_stb, busy
    );
endinterface

// File: rtl/reg_bus_arbiter.sv
// ---------------------------------------------------------------------------
// reg_bus_arbiter
//   Two-master round-robin arbiter and sequencer for the shared register-file
//   bus. Each granted access runs IDLE -> SETUP -> STROBE [-> RDWAIT] -> ACK:
//   address/wdata are registered at grant, a one-cycle xfc (write) or rd_stb
//   (read) strobe is issued, read data is captured RD_LAT cycles after the
//   strobe, and the winning master gets a one-cycle ack (with err for an
//   out-of-range address, which skips the strobe entirely).
//
//   Ports
//     clk   : master clock
//     rst_n : asynchronous active-low reset; abandons any transaction
//     bus   : reg_bus_arbiter_if.slave (requests, acks, register bus, busy)
//
//   Parameters
//     ADDR_W, DATA_W : address / data widths
//     RD_LAT         : cycles from rd_stb to valid rdata (1..15)
//     ADDR_MAX       : highest legal register address
// ---------------------------------------------------------------------------
module reg_bus_arbiter #(
    parameter int              ADDR_W   = 11,
    parameter int              DATA_W   = 8,
    parameter int              RD_LAT   = 1,
    parameter logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(11'h7FF)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    reg_bus_arbiter_if.slave      bus
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        RDWAIT,
        ACK
    } state_t;

    localparam logic [3:0] RD_CNT_INIT = 4'(RD_LAT - 1);

    state_t            state_q, state_d;

    logic              last_grant_q;
    logic              grant_q;
    logic              we_q;
    logic              err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        cnt_q;
    logic [DATA_W-1:0] rdata_q;

    // Control strobes from the next-state logic to the datapath registers.
    logic              grant_load;
    logic              win;
    logic              err_set;
    logic              cnt_load;
    logic              cnt_dec;
    logic              capture;

    // ADDR_MAX - address, one bit wider: the top bit is set exactly when
    // the registered address lies above ADDR_MAX.
    logic [ADDR_W:0]   range_diff;
    logic              addr_bad;

    assign range_diff = {1'b0, ADDR_MAX} - {1'b0, addr_q};
    assign addr_bad   = range_diff[ADDR_W];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d      = state_q;
        grant_load   = 1'b0;
        win          = 1'b0;
        err_set      = 1'b0;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        capture      = 1'b0;
        bus.xfc      = 1'b0;
        bus.rd_stb   = 1'b0;
        bus.m0_ack   = 1'b0;
        bus.m0_err   = 1'b0;
        bus.m0_rdata = '0;
        bus.m1_ack   = 1'b0;
        bus.m1_err   = 1'b0;
        bus.m1_rdata = '0;
        bus.busy     = (state_q != IDLE);

        unique case (state_q)
            IDLE: begin
                if (bus.m0_req || bus.m1_req) begin
                    grant_load = 1'b1;
                    // On a tie the master that was not served last wins;
                    // otherwise the lone requester wins.
                    win     = (bus.m0_req && bus.m1_req) ? ~last_grant_q : bus.m1_req;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (addr_bad) begin
                    err_set = 1'b1;
                    state_d = ACK;
                end else begin
                    state_d = STROBE;
                end
            end
            STROBE: begin
                if (we_q) begin
                    bus.xfc = 1'b1;
                    state_d = ACK;
                end else begin
                    bus.rd_stb = 1'b1;
                    cnt_load   = 1'b1;
                    state_d    = RDWAIT;
                end
            end
            RDWAIT: begin
                if (cnt_q == 4'd0) begin
                    capture = 1'b1;
                    state_d = ACK;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ACK: begin
                // Read data is only presented on a successful read.
                if (grant_q) begin
                    bus.m1_ack = 1'b1;
                    bus.m1_err = err_q;
                    if (!err_q && !we_q) bus.m1_rdata = rdata_q;
                end else begin
                    bus.m0_ack = 1'b1;
                    bus.m0_err = err_q;
                    if (!err_q && !we_q) bus.m0_rdata = rdata_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Grant / bus datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            rdata_q      <= '0;
        end else begin
            if (grant_load) begin
                last_grant_q <= win;
                grant_q      <= win;
                we_q         <= win ? bus.m1_we    : bus.m0_we;
                addr_q       <= win ? bus.m1_addr  : bus.m0_addr;
                wdata_q      <= win ? bus.m1_wdata : bus.m0_wdata;
                err_q        <= 1'b0;
            end
            if (err_set) begin
                err_q <= 1'b1;
            end
            if (cnt_load) begin
                cnt_q <= RD_CNT_INIT;
            end else if (cnt_dec) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (capture) begin
                rdata_q <= bus.rdata;
            end
        end
    end

    // address/wdata simply hold their last granted values through IDLE.
    assign bus.address = addr_q;
    assign bus.wdata   = wdata_q;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_reg_bus_arbiter
//   Directed bench for reg_bus_arbiter built with RD_LAT=3 and ADDR_MAX=0x0FF.
//   Inputs change 1 time unit after the rising edge, outputs are read at the
//   same point, so every check sees settled registered values.
// ---------------------------------------------------------------------------
module tb_reg_bus_arbiter;

    localparam int               ADDR_W   = 11;
    localparam int               DATA_W   = 8;
    localparam int               RD_LAT   = 3;
    localparam logic [ADDR_W-1:0] ADDR_MAX = 11'h0FF;

    logic clk = 1'b0;
    logic rst_n;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int n_xfc = 0;
    int n_rd  = 0;
    int n_both = 0;

    reg_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

    reg_bus_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .RD_LAT   (RD_LAT),
        .ADDR_MAX (ADDR_MAX)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus_if.xfc)                 n_xfc++;
        if (bus_if.rd_stb)              n_rd++;
        if (bus_if.xfc && bus_if.rd_stb) n_both++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m0(input logic req, input logic we, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wd);
        bus_if.m0_req   = req;
        bus_if.m0_we    = we;
        bus_if.m0_addr  = addr;
        bus_if.m0_wdata = wd;
    endtask

    task automatic set_m1(input logic req, input logic we, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wd);
        bus_if.m1_req   = req;
        bus_if.m1_we    = we;
        bus_if.m1_addr  = addr;
        bus_if.m1_wdata = wd;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    int  x0, r0, tstart;
    logic got;

    initial begin
        set_m0(1'b0, 1'b0, '0, '0);
        set_m1(1'b0, 1'b0, '0, '0);
        bus_if.rdata = '0;
        rst_n = 1'b0;
        step();
        step();

        // ---------------- reset state ----------------
        check("rst_busy",     bus_if.busy,     0);
        check("rst_address",  bus_if.address,  0);
        check("rst_wdata",    bus_if.wdata,    0);
        check("rst_xfc",      bus_if.xfc,      0);
        check("rst_rd_stb",   bus_if.rd_stb,   0);
        check("rst_m0_ack",   bus_if.m0_ack,   0);
        check("rst_m1_ack",   bus_if.m1_ack,   0);
        check("rst_m0_err",   bus_if.m0_err,   0);
        check("rst_m1_rdata", bus_if.m1_rdata, 0);
        rst_n = 1'b1;
        step();

        // ---------------- single write, m0 ----------------
        x0 = n_xfc; r0 = n_rd;
        set_m0(1'b1, 1'b1, 11'h008, 8'h15);          // cycle T
        step();                                       // T+1
        check("wr_addr_t1",  bus_if.address, 11'h008);
        check("wr_wdata_t1", bus_if.wdata,   8'h15);
        check("wr_xfc_t1",   bus_if.xfc,     0);
        check("wr_busy_t1",  bus_if.busy,    1);
        step();                                       // T+2
        check("wr_xfc_t2",   bus_if.xfc,     1);
        check("wr_ack_t2",   bus_if.m0_ack,  0);
        step();                                       // T+3
        check("wr_ack_t3",   bus_if.m0_ack,  1);
        check("wr_err_t3",   bus_if.m0_err,  0);
        check("wr_rdata_t3", bus_if.m0_rdata, 0);
        check("wr_xfc_t3",   bus_if.xfc,     0);
        step();                                       // T+4
        set_m0(1'b0, 1'b0, '0, '0);
        check("wr_ack_t4",   bus_if.m0_ack,  0);
        check("wr_busy_t4",  bus_if.busy,    0);
        check("wr_xfc_cnt",  n_xfc - x0, 1);
        check("wr_rd_cnt",   n_rd - r0,  0);

        // ---------------- read, m1, RD_LAT=3 ----------------
        x0 = n_xfc; r0 = n_rd;
        bus_if.rdata = 8'h3C;
        set_m1(1'b1, 1'b0, 11'h010, 8'h00);          // T
        step();                                       // T+1
        check("rd_addr_t1",  bus_if.address, 11'h010);
        step();                                       // T+2
        check("rd_stb_t2",   bus_if.rd_stb,  1);
        check("rd_xfc_t2",   bus_if.xfc,     0);
        step();                                       // T+3
        check("rd_stb_t3",   bus_if.rd_stb,  0);
        check("rd_ack_t3",   bus_if.m1_ack,  0);
        step();                                       // T+4
        check("rd_ack_t4",   bus_if.m1_ack,  0);
        step();                                       // T+5
        check("rd_ack_t5",   bus_if.m1_ack,  0);
        bus_if.rdata = 8'hA5;
        step();                                       // T+6
        bus_if.rdata = 8'h5A;
        check("rd_ack_t6",   bus_if.m1_ack,  1);
        check("rd_rdata_t6", bus_if.m1_rdata, 8'hA5);
        check("rd_err_t6",   bus_if.m1_err,  0);
        check("rd_m0ack_t6", bus_if.m0_ack,  0);
        step();                                       // T+7
        set_m1(1'b0, 1'b0, '0, '0);
        check("rd_ack_t7",   bus_if.m1_ack,  0);
        check("rd_rdata_t7", bus_if.m1_rdata, 0);
        check("rd_xfc_cnt",  n_xfc - x0, 0);
        check("rd_rd_cnt",   n_rd - r0,  1);

        // ---------------- simultaneous requests / fairness ----------------
        do_reset();
        set_m0(1'b1, 1'b1, 11'h020, 8'h11);
        set_m1(1'b1, 1'b1, 11'h030, 8'h22);
        tstart = cyc;                                 // T
        for (int k = 0; k < 8; k++) begin
            got = 1'b0;
            for (int w = 0; w < 12 && !got; w++) begin
                step();
                if (bus_if.m0_ack || bus_if.m1_ack) got = 1'b1;
            end
            if (!got) begin
                check("fair_timeout", 0, 1);
            end else begin
                check($sformatf("fair_who_%0d", k), bus_if.m1_ack, k % 2);
                check($sformatf("fair_cyc_%0d", k), cyc - tstart, 3 + 4 * k);
                check($sformatf("fair_addr_%0d", k), bus_if.address,
                      (k % 2 == 0) ? 11'h020 : 11'h030);
            end
        end
        step();
        set_m0(1'b0, 1'b0, '0, '0);
        set_m1(1'b0, 1'b0, '0, '0);
        step();
        check("fair_busy_end", bus_if.busy, 0);

        // ---------------- address error, m0 ----------------
        x0 = n_xfc; r0 = n_rd;
        set_m0(1'b1, 1'b1, 11'h100, 8'h77);          // T
        step();                                       // T+1
        check("err_addr_t1", bus_if.address, 11'h100);
        check("err_ack_t1",  bus_if.m0_ack,  0);
        step();                                       // T+2
        check("err_ack_t2",   bus_if.m0_ack,   1);
        check("err_err_t2",   bus_if.m0_err,   1);
        check("err_rdata_t2", bus_if.m0_rdata, 0);
        check("err_xfc_t2",   bus_if.xfc,      0);
        step();                                       // T+3
        set_m0(1'b0, 1'b0, '0, '0);
        check("err_ack_t3",  bus_if.m0_ack, 0);
        check("err_err_t3",  bus_if.m0_err, 0);
        check("err_xfc_cnt", n_xfc - x0, 0);
        check("err_rd_cnt",  n_rd - r0,  0);

        // ---------------- reset mid-write ----------------
        set_m0(1'b1, 1'b1, 11'h040, 8'h44);          // T
        step();                                       // T+1, SETUP
        check("mrst_busy_setup", bus_if.busy, 1);
        x0 = n_xfc;
        rst_n = 1'b0;
        #1;
        check("mrst_address", bus_if.address, 0);
        check("mrst_wdata",   bus_if.wdata,   0);
        check("mrst_busy",    bus_if.busy,    0);
        check("mrst_xfc",     bus_if.xfc,     0);
        set_m0(1'b0, 1'b0, '0, '0);
        set_m1(1'b1, 1'b1, 11'h050, 8'h55);
        step();
        step();
        check("mrst_m0_ack",  bus_if.m0_ack, 0);
        check("mrst_m1_ack",  bus_if.m1_ack, 0);
        check("mrst_xfc_cnt", n_xfc - x0, 0);
        rst_n = 1'b1;                                 // T'
        step();                                       // T'+1
        check("mrst_m1_addr", bus_if.address, 11'h050);
        check("mrst_m1_busy", bus_if.busy,    1);
        step();                                       // T'+2
        check("mrst_m1_xfc",  bus_if.xfc,     1);
        step();                                       // T'+3
        check("mrst_m1_ack3", bus_if.m1_ack,  1);
        check("mrst_m0_ack3", bus_if.m0_ack,  0);
        step();
        set_m1(1'b0, 1'b0, '0, '0);
        check("mrst_xfc_total", n_xfc - x0, 1);

        // ---------------- late request during STROBE ----------------
        set_m0(1'b1, 1'b1, 11'h060, 8'h66);          // T
        step();                                       // T+1
        step();                                       // T+2, STROBE
        set_m1(1'b1, 1'b1, 11'h070, 8'h77);
        step();                                       // T+3, ACK
        check("late_m0_ack", bus_if.m0_ack, 1);
        check("late_m1_ack", bus_if.m1_ack, 0);
        step();                                       // T+4, IDLE
        set_m0(1'b0, 1'b0, '0, '0);
        check("late_busy_idle", bus_if.busy,    0);
        check("late_addr_hold", bus_if.address, 11'h060);
        step();                                       // T+5
        check("late_m1_addr",  bus_if.address, 11'h070);
        check("late_m1_wdata", bus_if.wdata,   8'h77);
        step();                                       // T+6
        check("late_m1_xfc",   bus_if.xfc,     1);
        step();                                       // T+7
        check("late_m1_ack7",  bus_if.m1_ack,  1);
        check("late_m0_ack7",  bus_if.m0_ack,  0);
        step();
        set_m1(1'b0, 1'b0, '0, '0);
        step();

        check("strobe_overlap", n_both, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_bus_arbiter.md
Name: reg_bus_arbiter

Overview:
- Two-master arbiter and sequencer for the shared register-file bus (address, wdata, xfc, rd_stb, rdata). This bus also feeds the write-1-to-clear trigger logic.
- Master 0 is the SPI slave front end; master 1 is the I2C slave front end.
- Serialises accesses with round-robin priority and generates the one-cycle xfc write strobe and rd_stb read strobe.
- Returns a one-cycle ack, plus read data or an error, to the winning master.

Parameters:
ADDR_W, 11, register address width
DATA_W, 8, register data width
RD_LAT, 1, cycles from rd_stb to valid rdata (legal 1..15)
ADDR_MAX, 11'h7FF, highest legal register address; above this, the access errors

Ports:
clk  input  1  master clock
rst_n  input  1  asynchronous active-low reset
m0_req  input  1  master 0 request; held high until m0_ack
m0_we  input  1  master 0 write (1) / read (0)
m0_addr  input  ADDR_W  master 0 address
m0_wdata  input  DATA_W  master 0 write data
m0_ack  output  1  master 0 completion pulse
m0_err  output  1  master 0 error, valid with m0_ack
m0_rdata  output  DATA_W  master 0 read data, valid with m0_ack
m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_err, m1_rdata: same as master 0, for master 1
address  output  ADDR_W  register bus address
wdata  output  DATA_W  register bus write data
xfc  output  1  write transfer-complete strobe (writes only)
rd_stb  output  1  read strobe (reads only)
rdata  input  DATA_W  register file read data
busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values: all outputs 0; state IDLE; last_grant=1, so master 0 wins the first tie.
- Reset mid-transaction: the transaction is abandoned with no ack and no strobe. Requesters re-issue after reset.
- FSM states: IDLE, SETUP, STROBE, RDWAIT, ACK.
- IDLE (cycle T):
  - If any req is high, grant one master.
  - Single requester: it wins.
  - Both requesting: grant the master != last_grant, then update last_grant.
  - At the end of T, register the winner's addr, wdata and we into address, wdata and an internal we; go to SETUP.
- SETUP (T+1):
  - address and wdata are driven and stable; xfc=rd_stb=0.
  - If address > ADDR_MAX, go to ACK with err flagged.
  - Otherwise go to STROBE.
- STROBE (T+2):
  - Write: xfc=1 for exactly this cycle, then go to ACK.
  - Read: rd_stb=1 for exactly this cycle, then go to RDWAIT, loading a 4-bit counter with RD_LAT-1.
- RDWAIT: decrement the counter each cycle. In the cycle the counter is 0, capture rdata and go to ACK.
  - rdata is captured in cycle T+2+RD_LAT.
- ACK: mN_ack=1 for one cycle for the granted master, then go to IDLE.
  - mN_err=1 only on the address-error path.
  - mN_rdata shows the captured data on a good read; otherwise 0.
  - Outside ACK, ack, err and rdata are all 0.
- Latency from request sampled in IDLE at T:
  - write: ack at T+3
  - read: ack at T+3+RD_LAT
  - error: ack at T+2
  - Back-to-back: the next grant can occur in the IDLE cycle after ACK, so at most one transaction per 4 cycles (writes).
- address and wdata hold their last values through IDLE; they are not cleared.
- xfc and rd_stb are never high together and never high outside STROBE.
- A request seen during any non-IDLE state waits; it is never dropped.
- Requester contract: req, we, addr and wdata stay stable from assertion through the ack cycle. req is deasserted in the cycle after ack, or re-asserted for a new access.
  - A req dropped before grant is simply not served.
  - Once granted, a transaction always completes, even if req falls.
- Fairness: with both masters continuously requesting, grants alternate 0,1,0,1.

Test Plan:
- Single write: m0 writes addr 11'h008, wdata 8'h15 at T -> address=11'h008 and wdata=8'h15 from T+1; xfc=1 only at T+2; m0_ack=1 at T+3, m0_err=0; rd_stb never high.
- Read with RD_LAT=3: m1 reads 11'h010, model drives rdata=8'hA5 at T+5 -> rd_stb=1 at T+2; m1_ack=1 with m1_rdata=8'hA5 at T+6; xfc never high.
- Simultaneous requests after reset: m0 and m1 both write at T -> m0 served first (ack T+3), m1 granted at T+4 (ack T+7); with both held, grants continue alternating 0,1,0,1 over 8 transactions.
- Address error with ADDR_MAX=11'h0FF: m0 writes 11'h100 -> no xfc or rd_stb; m0_ack=1 and m0_err=1 at T+2; m0_rdata=0.
- Reset mid-write: rst_n low during SETUP -> all outputs 0 immediately, no xfc, no ack. After release, a pending m1 request is granted first (last_grant=1 rule gives tie to m0 only when both are requesting).
- Late request: m1 raises req during m0's STROBE -> m1 is not granted until m0's ACK completes; m1's address appears on the bus in the cycle after that IDLE.
